// File: rtl/xmt_controller.sv
// xmt_controller: transmit-side frame controller.
// Buffers payload bytes written from the UART side while idle, then serialises
// preamble, SFD, dest, src (MAC), type, payload and FCS to the byte transmitter
// over a valid/ready handshake. Sends type-8'h33 ACK frames (no payload) when the
// receive path raises ACK_needed; ACK frames leave the payload buffer untouched.
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   MAC, xdata, xwr, xsend, xdest,    own address, payload write port, send request
//   xtype                             with its latched dest/type
//   ACK_needed, ack_frame_addr        ACK request level and ACK destination
//   fcs, crc_clr, crc_enb             CRC generator result and controls
//   tx_data, tx_valid, tx_ready       byte stream to the transmitter
//   ack_sent, xbusy, xerrcnt          ACK done pulse, frame in progress, dropped writes
module xmt_controller #(
    parameter int         PREAMBLE_LENGTH = 1,
    parameter logic [7:0] SFD             = 8'hD0,
    parameter int         MAX_DATA        = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] MAC,
    input  logic [7:0] xdata,
    input  logic       xwr,
    input  logic       xsend,
    input  logic [7:0] xdest,
    input  logic [7:0] xtype,
    input  logic       ACK_needed,
    input  logic [7:0] ack_frame_addr,
    input  logic [7:0] fcs,
    output logic       crc_clr,
    output logic       crc_enb,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       ack_sent,
    output logic       xbusy,
    output logic [7:0] xerrcnt
);
    localparam int CW = $clog2(MAX_DATA + 1);
    localparam int PW = $clog2(PREAMBLE_LENGTH + 1);

    typedef enum logic [2:0] {IDLE, PRE, SFD_S, DEST, SRC, TYPE, DATA, FCS} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [2**CW];
    logic [CW-1:0] count, wptr, rptr;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    dest_r, type_r;
    logic          is_ack, xfer, last, wr_ok, no_fcs;

    assign wr_ok   = xwr && state == IDLE && count < CW'(MAX_DATA);
    assign no_fcs  = type_r == 8'h30;
    assign xbusy   = state != IDLE;
    assign crc_clr = state == IDLE;

    always_comb begin
        state_nx = state;
        tx_valid = state != IDLE;
        tx_data  = 8'h00;
        crc_enb  = 1'b0;
        xfer     = tx_valid && tx_ready;
        case (state)
            IDLE:  state_nx = (ACK_needed || xsend) ? PRE : IDLE;
            PRE: begin
                tx_data = 8'h55;
                if (xfer && pre_cnt == PW'(PREAMBLE_LENGTH - 1)) state_nx = SFD_S;
            end
            SFD_S: begin
                tx_data = SFD;
                if (xfer) state_nx = DEST;
            end
            DEST: begin
                tx_data = dest_r;
                crc_enb = xfer;
                if (xfer) state_nx = SRC;
            end
            SRC: begin
                tx_data = MAC;
                crc_enb = xfer;
                if (xfer) state_nx = TYPE;
            end
            TYPE: begin
                tx_data = type_r;
                crc_enb = xfer;
                // ACK frames never carry payload even when the buffer holds bytes
                if (xfer) state_nx = (count != '0 && !is_ack) ? DATA : no_fcs ? IDLE : FCS;
            end
            DATA: begin
                tx_data = mem[rptr];
                crc_enb = xfer;
                if (xfer && rptr == count - CW'(1)) state_nx = no_fcs ? IDLE : FCS;
            end
            FCS: begin
                tx_data = fcs;
                if (xfer) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        last = xfer && state_nx == IDLE;
    end

    always_ff @(posedge clk)
        if (wr_ok) mem[wptr] <= xdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            pre_cnt  <= '0;
            dest_r   <= 8'h00;
            type_r   <= 8'h00;
            is_ack   <= 1'b0;
            ack_sent <= 1'b0;
            xerrcnt  <= 8'h00;
        end else begin
            state    <= state_nx;
            ack_sent <= last && is_ack;
            if (state == IDLE) begin
                pre_cnt <= '0;
                // ACK wins over a same-cycle xsend, which is then lost
                if (ACK_needed) begin
                    is_ack <= 1'b1;
                    dest_r <= ack_frame_addr;
                    type_r <= 8'h33;
                end else if (xsend) begin
                    is_ack <= 1'b0;
                    dest_r <= xdest;
                    type_r <= xtype;
                end
            end
            if (state == PRE && xfer) pre_cnt <= pre_cnt + PW'(1);
            if (state == DATA && xfer) rptr <= rptr + CW'(1);
            if (wr_ok) begin
                wptr  <= wptr + CW'(1);
                count <= count + CW'(1);
            end else if (xwr && xerrcnt != 8'hFF) begin
                xerrcnt <= xerrcnt + 8'd1;
            end
            if (last && !is_ack) begin
                count <= '0;
                wptr  <= '0;
                rptr  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_xmt_controller.sv
// tb_xmt_controller: randomized self-checking bench for xmt_controller.
// The reference model turns each requested frame into the list of bytes (with
// their expected crc_enb flag) that must appear on the transmitter handshake.
module tb_xmt_controller;
    localparam int PL = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mac = 8'h11;
    logic [7:0] xdata = 8'h00;
    logic       xwr = 1'b0;
    logic       xsend = 1'b0;
    logic [7:0] xdest = 8'h00;
    logic [7:0] xtype = 8'h00;
    logic       ACK_needed = 1'b0;
    logic [7:0] ack_frame_addr = 8'h00;
    logic [7:0] fcs_v = 8'h00;
    logic       crc_clr, crc_enb, tx_valid, ack_sent, xbusy;
    logic [7:0] tx_data, xerrcnt;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    int acks = 0;
    int model_err = 0;
    logic [7:0] model_buf [$];
    logic [8:0] exp_q [$];
    logic       stall = 1'b0;
    logic [7:0] stall_data = 8'h00;

    xmt_controller dut (
        .clk(clk), .rst(rst), .MAC(mac), .xdata(xdata), .xwr(xwr), .xsend(xsend),
        .xdest(xdest), .xtype(xtype), .ACK_needed(ACK_needed), .ack_frame_addr(ack_frame_addr),
        .fcs(fcs_v), .crc_clr(crc_clr), .crc_enb(crc_enb), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .ack_sent(ack_sent), .xbusy(xbusy),
        .xerrcnt(xerrcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transfers are judged mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            stall = 1'b0;
        end else begin
            if (tx_valid && stall) check("stable", 32'(tx_data), 32'(stall_data));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_q[0][7:0]));
                    check("crc_enb", 32'(crc_enb), 32'(exp_q[0][8]));
                    void'(exp_q.pop_front());
                end
                stall = 1'b0;
            end else begin
                check("crc_idle", 32'(crc_enb), 32'd0);
                stall = tx_valid;
                stall_data = tx_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_sent) begin
            ACK_needed = 1'b0;
            acks++;
        end
        tx_ready = $urandom_range(99) < ready_pct;
    endtask

    task automatic err_inc();
        if (model_err < 255) model_err++;
    endtask

    task automatic write_byte(input logic [7:0] b);
        xdata = b;
        xwr = 1'b1;
        if (model_buf.size() < 255) model_buf.push_back(b);
        else err_inc();
        tick();
        xwr = 1'b0;
    endtask

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) write_byte(8'($urandom));
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [7:0] t, input bit ack);
        for (int i = 0; i < PL; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD0});
        exp_q.push_back({1'b1, d});
        exp_q.push_back({1'b1, mac});
        exp_q.push_back({1'b1, t});
        if (!ack) begin
            foreach (model_buf[i]) exp_q.push_back({1'b1, model_buf[i]});
            model_buf.delete();
        end
        if (t != 8'h30) exp_q.push_back({1'b0, fcs_v});
    endtask

    task automatic start_user(input logic [7:0] d, input logic [7:0] t, input bit extras, input bit mid_ack);
        xdest = d;
        xtype = t;
        xsend = 1'b1;
        push_frame(d, t, 1'b0);
        tick();
        xsend = 1'b0;
        if (extras) begin
            // busy now: the write is dropped, the second xsend ignored
            xwr = 1'b1;
            xdata = 8'($urandom);
            xsend = 1'b1;
            xdest = 8'($urandom);
            err_inc();
            if (mid_ack) begin
                ack_frame_addr = 8'($urandom);
                ACK_needed = 1'b1;
                push_frame(ack_frame_addr, 8'h33, 1'b1);
            end
            tick();
            xwr = 1'b0;
            xsend = 1'b0;
        end
    endtask

    task automatic start_ack(input logic [7:0] a, input bit with_xsend);
        ack_frame_addr = a;
        ACK_needed = 1'b1;
        if (with_xsend) begin
            xsend = 1'b1;
            xdest = 8'($urandom);
            xtype = 8'h31;
        end
        push_frame(a, 8'h33, 1'b1);
        tick();
        xsend = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || xbusy || ACK_needed) && n < 4000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(xbusy), 32'd0);
        check({tag, "_xerr"}, 32'(xerrcnt), 32'(model_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(xbusy), 32'd0);
        check("rst_ack", 32'(ack_sent), 32'd0);
        check("rst_crc_clr", 32'(crc_clr), 32'd1);
        check("rst_crc_enb", 32'(crc_enb), 32'd0);
        check("rst_xerr", 32'(xerrcnt), 32'd0);
        rst = 1'b1;
        ready_pct = 100;
        tick();

        // type 30: no FCS
        write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
        start_user(8'h2A, 8'h30, 1'b0, 1'b0);
        wait_done("t1");

        // type 31 with FCS
        fcs_v = 8'h5A;
        write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
        start_user(8'h2A, 8'h31, 1'b0, 1'b0);
        wait_done("t2");

        // ACK wins over same-cycle xsend, buffer kept for the next frame
        fcs_v = 8'h3C;
        write_bytes(2);
        a0 = acks;
        start_ack(8'h07, 1'b1);
        wait_done("t3");
        check("t3_ack_pulses", 32'(acks - a0), 32'd1);
        start_user(8'h44, 8'h31, 1'b0, 1'b0);
        wait_done("t3u");
        check("t3u_ack_pulses", 32'(acks - a0), 32'd1);

        // overflow: 257 writes keep 255, then a stalling full frame
        write_bytes(257);
        check("t5_xerr", 32'(xerrcnt), 32'(model_err));
        ready_pct = 60;
        fcs_v = 8'($urandom);
        start_user(8'h55, 8'h31, 1'b1, 1'b0);
        wait_done("t5");

        for (int it = 0; it < 30; it++) begin
            int mode;
            ready_pct = $urandom_range(100, 30);
            fcs_v = 8'($urandom);
            write_bytes($urandom_range(12));
            mode = $urandom_range(2);
            a0 = acks;
            if (mode == 2) begin
                start_ack(8'($urandom), 1'($urandom));
            end else begin
                start_user(8'($urandom), ($urandom_range(3) == 0) ? 8'h30 : 8'($urandom),
                           1'($urandom) || mode == 1, mode == 1);
            end
            wait_done("rnd");
            check("rnd_ack_pulses", 32'(acks - a0), 32'(mode != 0));
        end

        // reset in the middle of the payload
        ready_pct = 100;
        fcs_v = 8'h77;
        write_bytes(5);
        start_user(8'h66, 8'h31, 1'b1, 1'b0);
        a0 = 0;
        while (exp_q.size() > 4 && a0 < 100) begin
            tick();
            a0++;
        end
        check("t6_in_data", 32'(exp_q.size() <= 4), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_valid", 32'(tx_valid), 32'd0);
        check("t6_busy", 32'(xbusy), 32'd0);
        check("t6_crc_clr", 32'(crc_clr), 32'd1);
        exp_q.delete();
        model_buf.delete();
        model_err = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_xerr", 32'(xerrcnt), 32'd0);
        start_user(8'h12, 8'h31, 1'b0, 1'b0);
        wait_done("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
